// File: rtl/alu_input_loader.sv
// Operand/opcode loader for the TP1 ALU: sync + debounce + edge-detect per button, ordered A -> B -> OP capture.
// Optional debouncer selected by `define LOADER_DEBOUNCE_EN (undefined: deb level is the synchronizer output).
module alu_input_loader #(
    parameter int NB_BITS         = 8,
    parameter int NB_OPE          = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NB_CNT          = 20
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BITS-1:0] i_switch,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_BITS-1:0] o_dato_a,
    output logic [NB_BITS-1:0] o_dato_b,
    output logic [NB_OPE-1:0]  o_ope_sel,
    output logic               o_valid,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        READY   = 2'd3
    } state_t;

    localparam int NB_BTN = 3;

    if (NB_OPE > NB_BITS || DEBOUNCE_CYCLES < 1 || NB_CNT < 1) begin : g_param_check
        $error("alu_input_loader: invalid parameter combination");
    end

    logic [NB_BTN-1:0] btn_raw;
    logic [NB_BTN-1:0] strobe;

    assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

    genvar gi;
    generate
        for (gi = 0; gi < NB_BTN; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic deb_level;
            logic deb_d_reg;

            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_d_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_level;
                end
            end

`ifdef LOADER_DEBOUNCE_EN
            localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
            logic [NB_CNT-1:0] cnt_reg;

            // Any cycle where the synchronized level agrees with deb restarts the window.
            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    deb_level <= 1'b0;
                    cnt_reg   <= '0;
                end else if (sync2_reg != deb_level) begin
                    if (cnt_reg == CNT_LAST) begin
                        deb_level <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
`else
            assign deb_level = sync2_reg;
`endif

            assign strobe[gi] = deb_level & ~deb_d_reg;
        end
    endgenerate

    state_t              state_reg;
    logic [NB_BITS-1:0]  dato_a_reg;
    logic [NB_BITS-1:0]  dato_b_reg;
    logic [NB_OPE-1:0]   ope_sel_reg;
    logic                valid_reg;

    // Strobes that do not match the current WAIT_* state are dropped entirely.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_reg   <= WAIT_A;
            dato_a_reg  <= '0;
            dato_b_reg  <= '0;
            ope_sel_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_A: begin
                    if (strobe[0]) begin
                        dato_a_reg <= i_switch;
                        state_reg  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (strobe[1]) begin
                        dato_b_reg <= i_switch;
                        state_reg  <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (strobe[2]) begin
                        ope_sel_reg <= i_switch[NB_OPE-1:0];
                        state_reg   <= READY;
                        valid_reg   <= 1'b1;
                    end
                end
                READY: begin
                    if (strobe[0]) dato_a_reg  <= i_switch;
                    if (strobe[1]) dato_b_reg  <= i_switch;
                    if (strobe[2]) ope_sel_reg <= i_switch[NB_OPE-1:0];
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= WAIT_A;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_dato_a  = dato_a_reg;
    assign o_dato_b  = dato_b_reg;
    assign o_ope_sel = ope_sel_reg;
    assign o_valid   = valid_reg;
    assign o_state   = state_reg;

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader; expected load edge follows the LOADER_DEBOUNCE_EN build option.
`timescale 1ns/1ps
module tb_alu_input_loader;

`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       btn_a, btn_b, btn_op;
    logic [7:0] dato_a, dato_b;
    logic [5:0] ope_sel;
    logic       valid;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    alu_input_loader #(
        .NB_BITS(8), .NB_OPE(6), .DEBOUNCE_CYCLES(4), .NB_CNT(20)
    ) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .i_switch (sw),
        .i_btn_a  (btn_a),
        .i_btn_b  (btn_b),
        .i_btn_op (btn_op),
        .o_dato_a (dato_a),
        .o_dato_b (dato_b),
        .o_ope_sel(ope_sel),
        .o_valid  (valid),
        .o_state  (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [7:0] get_out(input int which);
        case (which)
            0:       return dato_a;
            1:       return dato_b;
            default: return {2'b00, ope_sel};
        endcase
    endfunction

    // Caller raises the button just after an edge; this checks the value one edge before and at edge LAT.
    task automatic watch_load(input int which, input logic [7:0] old_v, input logic [7:0] new_v,
                              input string tag);
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == LAT - 1) check({tag, "_before"}, 32'(get_out(which)), 32'(old_v));
        end
        check(tag, 32'(get_out(which)), 32'(new_v));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        sw = 8'h00;
        do_reset();
        step();
        check("rst_a",     32'(dato_a),  32'h0);
        check("rst_b",     32'(dato_b),  32'h0);
        check("rst_op",    32'(ope_sel), 32'h0);
        check("rst_valid", 32'(valid),   32'h0);
        check("rst_state", 32'(state),   32'h0);

        // Full A -> B -> OP sequence, each button held 10 cycles.
        sw = 8'h05; btn_a = 1'b1;
        watch_load(0, 8'h00, 8'h05, "seq_a");
        check("seq_state1", 32'(state), 32'd1);
        steps(10 - LAT); btn_a = 1'b0; steps(12);
        check("seq_a_held", 32'(dato_a), 32'h05);

        sw = 8'hFB; btn_b = 1'b1;
        watch_load(1, 8'h00, 8'hFB, "seq_b");
        check("seq_state2", 32'(state), 32'd2);
        steps(10 - LAT); btn_b = 1'b0; steps(12);

        sw = 8'h20; btn_op = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == LAT - 1) check("seq_valid_before", 32'(valid), 32'd0);
        end
        check("seq_op",     32'(ope_sel), 32'h20);
        check("seq_valid",  32'(valid),   32'd1);
        check("seq_state3", 32'(state),   32'd3);
        steps(10 - LAT); btn_op = 1'b0; steps(12);
        check("seq_a_final", 32'(dato_a), 32'h05);
        check("seq_b_final", 32'(dato_b), 32'hFB);

        // READY: simultaneous A and OP reload; switch changes while held must not reload.
        sw = 8'h3C; btn_a = 1'b1; btn_op = 1'b1;
        watch_load(0, 8'h05, 8'h3C, "rdy_a");
        check("rdy_op",    32'(ope_sel), 32'h3C);
        check("rdy_b",     32'(dato_b),  32'hFB);
        check("rdy_valid", 32'(valid),   32'd1);
        check("rdy_state", 32'(state),   32'd3);
        sw = 8'h11; steps(6);
        check("rdy_hold_a",  32'(dato_a),  32'h3C);
        check("rdy_hold_op", 32'(ope_sel), 32'h3C);
        btn_a = 1'b0; btn_op = 1'b0; steps(12);

        // Reset in the middle of a press; A must reload only after a fresh full window.
        sw = 8'h5A; btn_a = 1'b1;
        steps(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_a",     32'(dato_a),  32'h0);
        check("mid_rst_b",     32'(dato_b),  32'h0);
        check("mid_rst_op",    32'(ope_sel), 32'h0);
        check("mid_rst_valid", 32'(valid),   32'd0);
        check("mid_rst_state", 32'(state),   32'd0);
        watch_load(0, 8'h00, 8'h5A, "mid_rst_reload");
        check("mid_rst_state1", 32'(state), 32'd1);
        steps(4); btn_a = 1'b0; steps(12);

        // Order enforcement: B in WAIT_A is dropped.
        do_reset();
        sw = 8'hAA; btn_b = 1'b1;
        steps(10); btn_b = 1'b0; steps(12);
        check("order_b",     32'(dato_b), 32'h0);
        check("order_state", 32'(state),  32'd0);
        btn_a = 1'b1;
        watch_load(0, 8'h00, 8'hAA, "order_a");
        check("order_state1", 32'(state), 32'd1);
        check("order_b_after", 32'(dato_b), 32'h0);
        steps(4); btn_a = 1'b0; steps(12);

        do_reset();
        sw = 8'h77;
`ifdef LOADER_DEBOUNCE_EN
        // Bounce 1,0,1,0 then stable high: single load 7 edges into the stable level.
        for (int i = 0; i < 4; i++) begin
            btn_a = (i % 2 == 0);
            step();
        end
        check("bounce_none", 32'(dato_a), 32'h0);
        btn_a = 1'b1;
        watch_load(0, 8'h00, 8'h77, "bounce_load");
        check("bounce_state", 32'(state), 32'd1);
        steps(3); btn_a = 1'b0; steps(12);
`else
        // Without the debouncer a single-cycle glitch is a valid press.
        btn_a = 1'b1;
        step();
        btn_a = 1'b0;
        step();
        check("glitch_before", 32'(dato_a), 32'h0);
        step();
        check("glitch_load",  32'(dato_a), 32'h77);
        check("glitch_state", 32'(state),  32'd1);
        steps(6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_input_loader.md
Name: alu_input_loader

Overview:
Upstream operand/opcode loader for the TP1 ALU. Captures ALU operand A, operand B and the 6-bit operation code from the board switches, one value per push-button. Button inputs are synchronized, debounced and edge-detected. A, B and the opcode are held in registers that drive the ALU inputs directly; o_valid tells the top level when all three are loaded.

Parameters:
NB_BITS, 8, operand width and switch-bus width.
NB_OPE, 6, opcode width; the opcode is taken from i_switch[NB_OPE-1:0] (NB_OPE <= NB_BITS).
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a button change is accepted (>= 1; board build uses 1000000).
NB_CNT, 20, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
i_clock  input  1  system clock, all logic on rising edge.
i_reset  input  1  synchronous, active-low reset.
i_switch  input  NB_BITS  raw switch bus; quasi-static, not synchronized.
i_btn_a  input  1  raw button: load operand A.
i_btn_b  input  1  raw button: load operand B.
i_btn_op  input  1  raw button: load opcode.
o_dato_a  output  NB_BITS  registered operand A to ALU.
o_dato_b  output  NB_BITS  registered operand B to ALU.
o_ope_sel  output  NB_OPE  registered opcode to ALU.
o_valid  output  1  high while state == READY.
o_state  output  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset (i_reset==0 at a rising edge): o_dato_a=0, o_dato_b=0, o_ope_sel=0, o_valid=0, o_state=WAIT_A. Synchronizer flops, debounced states, delayed copies and counters all cleared. Reset mid-debounce discards the pending press.
- Per-button path (x = a, b, op):
  - Two-flop synchronizer: sync1 <= raw; sync2 <= sync1.
  - Debouncer: if sync2 != deb, cnt increments; else cnt <= 0. When sync2 != deb on an edge where cnt == DEBOUNCE_CYCLES-1, deb <= sync2 and cnt <= 0. Effect: deb follows sync2 after DEBOUNCE_CYCLES consecutive differing edges. Any bounce back resets cnt.
  - Edge detect: deb_d <= deb; strobe_x = deb & ~deb_d (combinational, one cycle wide). Release (falling) produces no strobe.
- Latency: raw high sampled at edge 1 -> deb high after edge DEBOUNCE_CYCLES+2 -> target register loaded at edge DEBOUNCE_CYCLES+3.
- Load: on strobe_a, o_dato_a <= i_switch; on strobe_b, o_dato_b <= i_switch; on strobe_op, o_ope_sel <= i_switch[NB_OPE-1:0]. A load is applied only if the FSM accepts that strobe (see below).
- FSM encoding: WAIT_A=2'd0, WAIT_B=2'd1, WAIT_OP=2'd2, READY=2'd3.
  - WAIT_A: accept strobe_a only -> WAIT_B.
  - WAIT_B: accept strobe_b only -> WAIT_OP.
  - WAIT_OP: accept strobe_op only -> READY.
  - READY: accept every strobe, including simultaneous ones. Each accepted strobe updates its register; the state stays READY.
  - In WAIT_* states, non-matching strobes are dropped: their register is unchanged and no state change occurs. Simultaneous strobes in a WAIT_* state: only the matching one is applied.
- o_valid = (state == READY), registered together with the state, so it rises on the same edge as the opcode load.
- Holding a button produces exactly one load. A new load requires release (deb falls) and a fresh press.

Optional Feature:
LOADER_DEBOUNCE_EN:
- Defined: debouncer and counters present, as above.
- Undefined: counters removed, deb is sync2 directly, DEBOUNCE_CYCLES and NB_CNT unused. Load latency is 3 edges. All other behaviour is identical.

Test Plan:
- Reset then sequence (DEBOUNCE_CYCLES=4, macro defined): switch 8'h05 + btn_a held 10 cycles, switch 8'hFB + btn_b, switch 8'h20 + btn_op -> o_dato_a=05, o_dato_b=FB, o_ope_sel=6'h20, o_valid=1, o_state=3; o_dato_a loads exactly at edge 7 after press.
- Bounce: btn_a toggles 1,0,1,0 on consecutive cycles, then holds high 10 cycles -> exactly one load, at edge 7 after the start of the stable level; no earlier load.
- Order enforcement: in WAIT_A, press btn_b with switch 8'hAA -> o_dato_b stays 00, o_state stays 0; then press btn_a -> o_state=1.
- READY reload: in READY, press btn_a and btn_op together with switch 8'h3C -> o_dato_a=3C, o_ope_sel=6'h3C, o_valid stays 1.
- Reset mid-debounce: btn_a high 3 cycles, i_reset=0 for one edge, btn_a kept high -> all outputs 0; A loads only after a full new debounce window.
- Macro undefined: btn_a rising sampled at edge 1 -> o_dato_a updated at edge 3; a 1-cycle glitch still produces a load.
